// File: rtl/multicycle_control.sv
// Multi-cycle LEGv8 sequencer: FSM driving datapath strobes with memory-ready handshake and timeout.
// Optional build macro PERF_COUNTERS_EN adds cycle and retired-instruction counters.
module multicycle_control #(
  parameter int WAIT_LIMIT = 255
`ifdef PERF_COUNTERS_EN
  ,
  parameter int CNT_WIDTH  = 32
`endif
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [10:0] i_opcode,
  input  logic        i_zero,
  input  logic        i_memReady,
  output logic [1:0]  o_signOp,
  output logic        o_reg2Loc,
  output logic        o_aluSrc,
  output logic [1:0]  o_aluOp,
  output logic        o_memRead,
  output logic        o_memWrite,
  output logic        o_memToReg,
  output logic        o_regWrite,
  output logic        o_irWrite,
  output logic        o_pcWrite,
  output logic        o_pcSrc,
  output logic        o_instrDone,
  output logic        o_illegal,
  output logic        o_memFault,
  output logic [3:0]  o_state
`ifdef PERF_COUNTERS_EN
  ,
  output logic [CNT_WIDTH-1:0] o_cycleCount,
  output logic [CNT_WIDTH-1:0] o_instrCount
`endif
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_EXEC_R = 4'd2,
    S_WB_R   = 4'd3,
    S_ADDR   = 4'd4,
    S_MEM_RD = 4'd5,
    S_WB_MEM = 4'd6,
    S_MEM_WR = 4'd7,
    S_BR_U   = 4'd8,
    S_BR_C   = 4'd9
  } state_t;

  localparam logic [7:0]  WAIT_LIMIT_M1 = 8'(WAIT_LIMIT - 1);
  localparam logic [10:0] OP_STUR       = 11'b11111000000;

  state_t     r_state;
  logic [1:0] r_signOp;
  logic [7:0] r_waitCnt;

  state_t     w_next;
  state_t     w_decNext;
  logic [1:0] w_decSignOp;
  logic       w_legal;
  logic       w_isStur;
  logic       w_memWait;
  logic       w_limitHit;
  logic       w_fault;

  assign w_isStur   = (i_opcode == OP_STUR);
  assign w_memWait  = (r_state == S_FETCH) || (r_state == S_MEM_RD) || (r_state == S_MEM_WR);
  assign w_limitHit = !i_memReady && (r_waitCnt == WAIT_LIMIT_M1);

  assign o_state  = r_state;
  assign o_signOp = r_signOp;

  always_comb begin
    w_legal     = 1'b1;
    w_decNext   = S_FETCH;
    w_decSignOp = 2'b00;
    casez (i_opcode)
      11'b10001011000, 11'b11001011000,
      11'b10001010000, 11'b10101010000: begin
        w_decNext   = S_EXEC_R;
        w_decSignOp = 2'b00;
      end
      11'b11111000010, 11'b11111000000: begin
        w_decNext   = S_ADDR;
        w_decSignOp = 2'b01;
      end
      11'b000101?????: begin
        w_decNext   = S_BR_U;
        w_decSignOp = 2'b10;
      end
      11'b10110100???: begin
        w_decNext   = S_BR_C;
        w_decSignOp = 2'b11;
      end
      default: w_legal = 1'b0;
    endcase
  end

  // Strobes must react to MemReady/Zero within the same cycle, so they are decoded
  // from the registered state rather than registered themselves.
  always_comb begin
    w_next      = r_state;
    w_fault     = 1'b0;
    o_reg2Loc   = 1'b0;
    o_aluSrc    = 1'b0;
    o_aluOp     = 2'b00;
    o_memRead   = 1'b0;
    o_memWrite  = 1'b0;
    o_memToReg  = 1'b0;
    o_regWrite  = 1'b0;
    o_irWrite   = 1'b0;
    o_pcWrite   = 1'b0;
    o_pcSrc     = 1'b0;
    o_instrDone = 1'b0;
    o_illegal   = 1'b0;
    case (r_state)
      S_FETCH: begin
        o_memRead = 1'b1;
        if (i_memReady) begin
          o_irWrite = 1'b1;
          o_pcWrite = 1'b1;
          w_next    = S_DECODE;
        end else if (w_limitHit) begin
          w_fault = 1'b1;
          w_next  = S_FETCH;
        end
      end
      S_DECODE: begin
        if (w_legal) begin
          w_next = w_decNext;
        end else begin
          o_illegal   = 1'b1;
          o_instrDone = 1'b1;
          w_next      = S_FETCH;
        end
      end
      S_EXEC_R: begin
        o_aluOp = 2'b10;
        w_next  = S_WB_R;
      end
      S_WB_R: begin
        o_regWrite  = 1'b1;
        o_instrDone = 1'b1;
        w_next      = S_FETCH;
      end
      S_ADDR: begin
        o_aluSrc  = 1'b1;
        o_reg2Loc = w_isStur;
        w_next    = w_isStur ? S_MEM_WR : S_MEM_RD;
      end
      S_MEM_RD: begin
        o_aluSrc  = 1'b1;
        o_memRead = 1'b1;
        if (i_memReady) begin
          w_next = S_WB_MEM;
        end else if (w_limitHit) begin
          w_fault     = 1'b1;
          o_instrDone = 1'b1;
          w_next      = S_FETCH;
        end
      end
      S_WB_MEM: begin
        o_memToReg  = 1'b1;
        o_regWrite  = 1'b1;
        o_instrDone = 1'b1;
        w_next      = S_FETCH;
      end
      S_MEM_WR: begin
        o_aluSrc   = 1'b1;
        o_reg2Loc  = 1'b1;
        o_memWrite = 1'b1;
        if (i_memReady) begin
          o_instrDone = 1'b1;
          w_next      = S_FETCH;
        end else if (w_limitHit) begin
          w_fault     = 1'b1;
          o_instrDone = 1'b1;
          w_next      = S_FETCH;
        end
      end
      S_BR_U: begin
        o_pcWrite   = 1'b1;
        o_pcSrc     = 1'b1;
        o_instrDone = 1'b1;
        w_next      = S_FETCH;
      end
      S_BR_C: begin
        o_reg2Loc   = 1'b1;
        o_aluOp     = 2'b01;
        o_pcSrc     = 1'b1;
        o_pcWrite   = i_zero;
        o_instrDone = 1'b1;
        w_next      = S_FETCH;
      end
      default: w_next = S_FETCH;
    endcase
    o_memFault = w_fault;
    // A reset cycle abandons whatever is in flight without touching PC, registers or memory.
    if (i_reset) begin
      o_reg2Loc   = 1'b0;
      o_aluSrc    = 1'b0;
      o_aluOp     = 2'b00;
      o_memRead   = 1'b0;
      o_memWrite  = 1'b0;
      o_memToReg  = 1'b0;
      o_regWrite  = 1'b0;
      o_irWrite   = 1'b0;
      o_pcWrite   = 1'b0;
      o_pcSrc     = 1'b0;
      o_instrDone = 1'b0;
      o_illegal   = 1'b0;
      o_memFault  = 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state   <= S_FETCH;
      r_signOp  <= 2'b00;
      r_waitCnt <= 8'd0;
    end else begin
      r_state <= w_next;
      if (r_state == S_DECODE && w_legal) begin
        r_signOp <= w_decSignOp;
      end
      // Any state change, including a fault back into FETCH, restarts the wait count.
      if (w_next != r_state || w_fault) begin
        r_waitCnt <= 8'd0;
      end else if (w_memWait && !i_memReady) begin
        r_waitCnt <= r_waitCnt + 8'd1;
      end
    end
  end

`ifdef PERF_COUNTERS_EN
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      o_cycleCount <= '0;
      o_instrCount <= '0;
    end else begin
      o_cycleCount <= o_cycleCount + 1'b1;
      if (o_instrDone && !o_illegal && !o_memFault) begin
        o_instrCount <= o_instrCount + 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: per-cycle expected vectors are queued by the
// stimulus and compared against the DUT by an independent negedge monitor.
module tb_multicycle_control;

  localparam logic [13:0] R2L  = 14'h2000;
  localparam logic [13:0] ASRC = 14'h1000;
  localparam logic [13:0] OPR  = 14'h0800;
  localparam logic [13:0] OPB  = 14'h0400;
  localparam logic [13:0] MRD  = 14'h0200;
  localparam logic [13:0] MWR  = 14'h0100;
  localparam logic [13:0] M2R  = 14'h0080;
  localparam logic [13:0] RW   = 14'h0040;
  localparam logic [13:0] IRW  = 14'h0020;
  localparam logic [13:0] PCW  = 14'h0010;
  localparam logic [13:0] PCS  = 14'h0008;
  localparam logic [13:0] DONE = 14'h0004;
  localparam logic [13:0] ILL  = 14'h0002;
  localparam logic [13:0] FLT  = 14'h0001;
  localparam logic [13:0] FOK  = MRD | IRW | PCW;

  localparam logic [10:0] OP_ADD  = 11'b10001011000;
  localparam logic [10:0] OP_LDUR = 11'b11111000010;
  localparam logic [10:0] OP_STUR = 11'b11111000000;
  localparam logic [10:0] OP_B    = 11'b00010100000;
  localparam logic [10:0] OP_CBZ  = 11'b10110100000;
  localparam logic [10:0] OP_BAD  = 11'b11111111111;

  typedef struct {
    logic [19:0] exp;
    string       name;
    logic [31:0] cyc;
    logic [31:0] ins;
    logic        chkCnt;
  } item_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [10:0] opcode;
  logic        zero;
  logic        memReady;
  logic [1:0]  signOp;
  logic        reg2Loc, aluSrc, memRead, memWrite, memToReg, regWrite;
  logic        irWrite, pcWrite, pcSrc, instrDone, illegal, memFault;
  logic [1:0]  aluOp;
  logic [3:0]  state;
`ifdef PERF_COUNTERS_EN
  logic [31:0] cycleCount, instrCount;
`endif

  item_t       sbQ[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] cycModel = 0;
  logic [31:0] insModel = 0;

  always #5 clk = ~clk;

  multicycle_control #(.WAIT_LIMIT(4)) dut (
    .i_clk(clk), .i_reset(reset), .i_opcode(opcode), .i_zero(zero), .i_memReady(memReady),
    .o_signOp(signOp), .o_reg2Loc(reg2Loc), .o_aluSrc(aluSrc), .o_aluOp(aluOp),
    .o_memRead(memRead), .o_memWrite(memWrite), .o_memToReg(memToReg), .o_regWrite(regWrite),
    .o_irWrite(irWrite), .o_pcWrite(pcWrite), .o_pcSrc(pcSrc), .o_instrDone(instrDone),
    .o_illegal(illegal), .o_memFault(memFault), .o_state(state)
`ifdef PERF_COUNTERS_EN
    , .o_cycleCount(cycleCount), .o_instrCount(instrCount)
`endif
  );

  // Drives one cycle of inputs and queues what the DUT must show during that cycle.
  task automatic applyStimulus(input logic rst, input logic [10:0] op, input logic z,
                               input logic rdy, input logic [3:0] st, input logic [1:0] so,
                               input logic [13:0] strb, input string name);
    item_t it;
    reset    = rst;
    opcode   = op;
    zero     = z;
    memReady = rdy;
    it.exp    = {st, so, strb};
    it.name   = name;
    it.cyc    = cycModel;
    it.ins    = insModel;
    it.chkCnt = !rst;
    sbQ.push_back(it);
    @(posedge clk);
    #1;
    if (rst) begin
      cycModel = 0;
      insModel = 0;
    end else begin
      cycModel = cycModel + 1;
      if (strb[2] && !strb[1] && !strb[0]) insModel = insModel + 1;
    end
  endtask

  task automatic checkOutput(input item_t it);
    logic [19:0] act;
    act = {state, signOp, reg2Loc, aluSrc, aluOp, memRead, memWrite, memToReg, regWrite,
           irWrite, pcWrite, pcSrc, instrDone, illegal, memFault};
    checks++;
    if (act !== it.exp) begin
      errors++;
      $display("[TB] FAIL %s: got %05h expected %05h", it.name, act, it.exp);
    end
`ifdef PERF_COUNTERS_EN
    if (it.chkCnt) begin
      checks++;
      if (cycleCount !== it.cyc || instrCount !== it.ins) begin
        errors++;
        $display("[TB] FAIL %s_counters: got cyc=%0d ins=%0d expected cyc=%0d ins=%0d",
                 it.name, cycleCount, instrCount, it.cyc, it.ins);
      end
    end
`endif
  endtask

  always @(negedge clk) begin
    if (sbQ.size() > 0) checkOutput(sbQ.pop_front());
  end

  initial begin
    reset = 1'b1; opcode = '0; zero = 1'b0; memReady = 1'b1;
    @(posedge clk);
    #1;
    applyStimulus(1, OP_ADD, 0, 1, 4'd0, 2'b00, 14'h0, "reset_hold");

    // ADD with memory always ready
    applyStimulus(0, OP_ADD, 0, 1, 4'd0, 2'b00, FOK, "add_fetch");
    applyStimulus(0, OP_ADD, 0, 1, 4'd1, 2'b00, 14'h0, "add_decode");
    applyStimulus(0, OP_ADD, 0, 1, 4'd2, 2'b00, OPR, "add_exec");
    applyStimulus(0, OP_ADD, 0, 1, 4'd3, 2'b00, RW | DONE, "add_wb");

    // LDUR with two wait cycles in MEM_RD
    applyStimulus(0, OP_LDUR, 0, 1, 4'd0, 2'b00, FOK, "ldur_fetch");
    applyStimulus(0, OP_LDUR, 0, 1, 4'd1, 2'b00, 14'h0, "ldur_decode");
    applyStimulus(0, OP_LDUR, 0, 1, 4'd4, 2'b01, ASRC, "ldur_addr");
    applyStimulus(0, OP_LDUR, 0, 0, 4'd5, 2'b01, ASRC | MRD, "ldur_wait1");
    applyStimulus(0, OP_LDUR, 0, 0, 4'd5, 2'b01, ASRC | MRD, "ldur_wait2");
    applyStimulus(0, OP_LDUR, 0, 1, 4'd5, 2'b01, ASRC | MRD, "ldur_memrd");
    applyStimulus(0, OP_LDUR, 0, 1, 4'd6, 2'b01, M2R | RW | DONE, "ldur_wb");

    // STUR with one wait in FETCH
    applyStimulus(0, OP_STUR, 0, 0, 4'd0, 2'b01, MRD, "stur_fetch_wait");
    applyStimulus(0, OP_STUR, 0, 1, 4'd0, 2'b01, FOK, "stur_fetch");
    applyStimulus(0, OP_STUR, 0, 1, 4'd1, 2'b01, 14'h0, "stur_decode");
    applyStimulus(0, OP_STUR, 0, 1, 4'd4, 2'b01, ASRC | R2L, "stur_addr");
    applyStimulus(0, OP_STUR, 0, 1, 4'd7, 2'b01, ASRC | R2L | MWR | DONE, "stur_memwr");

    // Unconditional branch
    applyStimulus(0, OP_B, 0, 1, 4'd0, 2'b01, FOK, "b_fetch");
    applyStimulus(0, OP_B, 0, 1, 4'd1, 2'b01, 14'h0, "b_decode");
    applyStimulus(0, OP_B, 0, 1, 4'd8, 2'b10, PCW | PCS | DONE, "b_bru");

    // CBZ taken then not taken
    applyStimulus(0, OP_CBZ, 1, 1, 4'd0, 2'b10, FOK, "cbz1_fetch");
    applyStimulus(0, OP_CBZ, 1, 1, 4'd1, 2'b10, 14'h0, "cbz1_decode");
    applyStimulus(0, OP_CBZ, 1, 1, 4'd9, 2'b11, R2L | OPB | PCS | PCW | DONE, "cbz_taken");
    applyStimulus(0, OP_CBZ, 0, 1, 4'd0, 2'b11, FOK, "cbz2_fetch");
    applyStimulus(0, OP_CBZ, 0, 1, 4'd1, 2'b11, 14'h0, "cbz2_decode");
    applyStimulus(0, OP_CBZ, 0, 1, 4'd9, 2'b11, R2L | OPB | PCS | DONE, "cbz_not_taken");

    // Illegal opcode keeps SignOp
    applyStimulus(0, OP_BAD, 0, 1, 4'd0, 2'b11, FOK, "bad_fetch");
    applyStimulus(0, OP_BAD, 0, 1, 4'd1, 2'b11, ILL | DONE, "bad_decode");

    // FETCH timeout at the 4th wait cycle, then refetch
    applyStimulus(0, OP_STUR, 0, 0, 4'd0, 2'b11, MRD, "fetch_wait1");
    applyStimulus(0, OP_STUR, 0, 0, 4'd0, 2'b11, MRD, "fetch_wait2");
    applyStimulus(0, OP_STUR, 0, 0, 4'd0, 2'b11, MRD, "fetch_wait3");
    applyStimulus(0, OP_STUR, 0, 0, 4'd0, 2'b11, MRD | FLT, "fetch_fault");
    applyStimulus(0, OP_STUR, 0, 0, 4'd0, 2'b11, MRD, "refetch_wait1");
    applyStimulus(0, OP_STUR, 0, 0, 4'd0, 2'b11, MRD, "refetch_wait2");
    applyStimulus(0, OP_STUR, 0, 0, 4'd0, 2'b11, MRD, "refetch_wait3");
    applyStimulus(0, OP_STUR, 0, 1, 4'd0, 2'b11, FOK, "ready_wins_limit");

    // Reset in MEM_WR abandons the store
    applyStimulus(0, OP_STUR, 0, 1, 4'd1, 2'b11, 14'h0, "stur2_decode");
    applyStimulus(0, OP_STUR, 0, 1, 4'd4, 2'b01, ASRC | R2L, "stur2_addr");
    applyStimulus(0, OP_STUR, 0, 0, 4'd7, 2'b01, ASRC | R2L | MWR, "stur2_memwr");
    applyStimulus(1, OP_STUR, 0, 0, 4'd7, 2'b01, 14'h0, "reset_in_memwr");
    applyStimulus(0, OP_LDUR, 0, 0, 4'd0, 2'b00, MRD, "after_reset");

    // MEM_RD timeout pulses MemFault and InstrDone together
    applyStimulus(0, OP_LDUR, 0, 1, 4'd0, 2'b00, FOK, "ldur2_fetch");
    applyStimulus(0, OP_LDUR, 0, 1, 4'd1, 2'b00, 14'h0, "ldur2_decode");
    applyStimulus(0, OP_LDUR, 0, 1, 4'd4, 2'b01, ASRC, "ldur2_addr");
    applyStimulus(0, OP_LDUR, 0, 0, 4'd5, 2'b01, ASRC | MRD, "memrd_wait1");
    applyStimulus(0, OP_LDUR, 0, 0, 4'd5, 2'b01, ASRC | MRD, "memrd_wait2");
    applyStimulus(0, OP_LDUR, 0, 0, 4'd5, 2'b01, ASRC | MRD, "memrd_wait3");
    applyStimulus(0, OP_LDUR, 0, 0, 4'd5, 2'b01, ASRC | MRD | FLT | DONE, "memrd_fault");
    applyStimulus(0, OP_ADD, 0, 1, 4'd0, 2'b01, FOK, "post_fault_fetch");
    applyStimulus(0, OP_ADD, 0, 1, 4'd1, 2'b01, 14'h0, "post_fault_decode");
    applyStimulus(0, OP_ADD, 0, 1, 4'd2, 2'b00, OPR, "post_fault_exec");

    @(negedge clk);
    checks++;
    if (sbQ.size() != 0) begin
      errors++;
      $display("[TB] FAIL scoreboard_drain: got %0d pending expected 0", sbQ.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
